// File: rtl/uart_in.sv
// ============================================================================
// Module   : uart_in
// Brief    : 8N1 serial receiver, LSB first, mid-bit sampling, framing errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_in #(
    parameter int BIT_SIZE = 10415,
    parameter int HALF_BIT = BIT_SIZE / 2,
    parameter int WORDSIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [WORDSIZE-1:0] data_out,
    output logic                data_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam logic [31:0] C_HALF_LAST = 32'(HALF_BIT - 1);
    localparam logic [31:0] C_BIT_LAST  = 32'(BIT_SIZE - 1);
    localparam logic [3:0]  C_LAST_IDX  = 4'(WORDSIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_BREAK = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [31:0]           r_cycles;
    logic [3:0]            r_bit_idx;
    logic [WORDSIZE-1:0]   r_shreg;
    logic [WORDSIZE-1:0]   r_data_out;
    logic                  w_rx_s;
    logic                  w_sample;

    assign w_rx_s = r_sync2;

    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_next_state = S_START;
            end
            S_START: begin
                if (r_cycles == C_HALF_LAST) begin
                    w_sample     = 1'b1;
                    w_next_state = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cycles == C_BIT_LAST) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == C_LAST_IDX) w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cycles == C_BIT_LAST) begin
                    w_sample     = 1'b1;
                    w_next_state = w_rx_s ? S_DONE : S_ERR;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_BREAK;
            // A held-low line must go high before another start is accepted.
            S_BREAK: begin
                if (w_rx_s) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= S_IDLE;
            r_cycles   <= 32'd0;
            r_bit_idx  <= 4'd0;
            r_shreg    <= '0;
            r_data_out <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_next_state;

            if ((w_next_state != r_state) || w_sample) begin
                r_cycles <= 32'd0;
            end else if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
                r_cycles <= r_cycles + 32'd1;
            end

            if ((r_state == S_START) && (w_next_state == S_DATA)) begin
                r_bit_idx <= 4'd0;
            end else if ((r_state == S_DATA) && w_sample) begin
                // Shifting in from the top leaves the first bit in the LSB.
                r_shreg   <= {w_rx_s, r_shreg[WORDSIZE-1:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
            end

            if ((r_state == S_STOP) && (w_next_state == S_DONE)) begin
                r_data_out <= r_shreg;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = (r_state == S_DONE);
    assign frame_err  = (r_state == S_ERR);
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
